// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 message front end.
// Holds block/length geometry, the padding marker byte and the padder state enum.
package sha256_pkg;

    localparam int unsigned SHA256_BLOCK_W     = 512;
    localparam int unsigned SHA256_LEN_FIELD_W = 64;
    localparam logic [7:0]  SHA256_PAD_BYTE    = 8'h80;
    localparam int unsigned SHA256_LEN_OFFSET  = 56;

    typedef enum logic [1:0] {
        StFill,
        StPad,
        StLen,
        StEmit
    } sha256_state_e;

endpackage

// File: rtl/sha256_pad_buffer.sv
// 64-byte block buffer for the SHA-256 padder.
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   i_clear        - zero the whole buffer
//   i_byte_we      - write i_byte_data at byte index i_byte_idx
//   i_byte_idx     - byte index 0..63 (byte 0 is the most significant byte of o_block)
//   i_byte_data    - byte to write
//   i_len_we       - write i_len big-endian into bytes 56..63
//   i_len          - 64-bit message bit length
//   o_block        - packed 512-bit block, byte 0 in [511:504]
module sha256_pad_buffer
    import sha256_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_clear,
    input  logic                          i_byte_we,
    input  logic [5:0]                    i_byte_idx,
    input  logic [7:0]                    i_byte_data,
    input  logic                          i_len_we,
    input  logic [SHA256_LEN_FIELD_W-1:0] i_len,
    output logic [SHA256_BLOCK_W-1:0]     o_block
);

    logic [7:0] r_mem [64];

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            for (int i = 0; i < 64; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else begin
            if (i_byte_we) begin
                r_mem[i_byte_idx] <= i_byte_data;
            end
            if (i_len_we) begin
                for (int i = 0; i < 8; i++) begin
                    r_mem[SHA256_LEN_OFFSET + i] <= i_len[63 - 8*i -: 8];
                end
            end
        end
    end

    always_comb begin
        o_block = '0;
        for (int i = 0; i < 64; i++) begin
            o_block[511 - 8*i -: 8] = r_mem[i];
        end
    end

endmodule

// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs a byte stream into 512-bit blocks and appends
// the 0x80 marker, zero fill and the 64-bit big-endian message bit length.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   data_in/valid/last/empty - input byte beat; empty with last marks a byteless end beat
//   data_ready               - beat accepted this cycle when data_valid is also high
//   block_out/valid/last     - output block, held until block_ready is sampled high
//   block_ready              - consumer accepts the block
module sha256_padder
    import sha256_pkg::*;
#(
    parameter int unsigned LEN_W = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                data_in,
    input  logic                      data_valid,
    input  logic                      data_last,
    input  logic                      data_empty,
    output logic                      data_ready,
    output logic [SHA256_BLOCK_W-1:0] block_out,
    output logic                      block_valid,
    output logic                      block_last,
    input  logic                      block_ready
);

    sha256_state_e r_state;
    sha256_state_e w_state_next;
    logic [6:0]    r_idx;
    logic [6:0]    w_idx_next;
    logic [LEN_W-1:0] r_bitcnt;
    logic [LEN_W-1:0] w_bitcnt_next;
    logic          r_pad_first;     // 0x80 still to be written
    logic          w_pad_first_next;
    logic          r_pad_pending;   // padding continues in a further block after EMIT
    logic          w_pad_pending_next;
    logic          r_last;
    logic          w_last_next;
    logic          r_run;           // holds data_ready low during and right after reset

    logic          w_accept;
    logic          w_store;
    logic          w_clear;
    logic          w_byte_we;
    logic [7:0]    w_byte_data;
    logic          w_len_we;
    logic [SHA256_LEN_FIELD_W-1:0] w_len64;

    assign data_ready  = r_run && (r_state == StFill);
    assign block_valid = (r_state == StEmit);
    assign block_last  = r_last;
    assign w_accept    = data_valid && data_ready;
    assign w_len64     = SHA256_LEN_FIELD_W'(r_bitcnt);

    always_comb begin
        w_state_next       = r_state;
        w_idx_next         = r_idx;
        w_bitcnt_next      = r_bitcnt;
        w_pad_first_next   = r_pad_first;
        w_pad_pending_next = r_pad_pending;
        w_last_next        = r_last;
        w_store            = 1'b0;
        w_clear            = 1'b0;
        w_byte_we          = 1'b0;
        w_byte_data        = data_in;
        w_len_we           = 1'b0;

        unique case (r_state)
            StFill: begin
                if (w_accept) begin
                    w_store = !(data_last && data_empty);
                    if (w_store) begin
                        w_byte_we     = 1'b1;
                        w_idx_next    = r_idx + 7'd1;
                        w_bitcnt_next = r_bitcnt + LEN_W'(8);
                    end
                    if (data_last) begin
                        w_pad_first_next = 1'b1;
                        if (w_store && (r_idx == 7'd63)) begin
                            // Block is full; the marker goes into a fresh block.
                            w_state_next       = StEmit;
                            w_pad_pending_next = 1'b1;
                        end else begin
                            w_state_next = StPad;
                        end
                    end else if (r_idx == 7'd63) begin
                        w_state_next = StEmit;
                    end
                end
            end
            StPad: begin
                w_byte_we        = 1'b1;
                w_byte_data      = r_pad_first ? SHA256_PAD_BYTE : 8'h00;
                w_pad_first_next = 1'b0;
                w_idx_next       = r_idx + 7'd1;
                if ((r_idx + 7'd1) == 7'(SHA256_LEN_OFFSET)) begin
                    w_state_next = StLen;
                end else if (r_idx == 7'd63) begin
                    // No room left for the length field in this block.
                    w_state_next       = StEmit;
                    w_pad_pending_next = 1'b1;
                end
            end
            StLen: begin
                w_len_we     = 1'b1;
                w_last_next  = 1'b1;
                w_state_next = StEmit;
            end
            StEmit: begin
                if (block_ready) begin
                    w_idx_next = 7'd0;
                    w_clear    = 1'b1;
                    if (r_pad_pending) begin
                        w_state_next       = StPad;
                        w_pad_pending_next = 1'b0;
                    end else begin
                        w_state_next = StFill;
                    end
                    if (r_last) begin
                        w_last_next   = 1'b0;
                        w_bitcnt_next = '0;
                    end
                end
            end
            default: begin
                w_state_next = StFill;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= StFill;
            r_idx         <= 7'd0;
            r_bitcnt      <= '0;
            r_pad_first   <= 1'b0;
            r_pad_pending <= 1'b0;
            r_last        <= 1'b0;
            r_run         <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_idx         <= w_idx_next;
            r_bitcnt      <= w_bitcnt_next;
            r_pad_first   <= w_pad_first_next;
            r_pad_pending <= w_pad_pending_next;
            r_last        <= w_last_next;
            r_run         <= 1'b1;
        end
    end

    sha256_pad_buffer u_buffer (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_clear),
        .i_byte_we   (w_byte_we),
        .i_byte_idx  (r_idx[5:0]),
        .i_byte_data (w_byte_data),
        .i_len_we    (w_len_we),
        .i_len       (w_len64),
        .o_block     (block_out)
    );

endmodule
